// File: rtl/matrix_result_streamer.sv
// ---------------------------------------------------------------------------
// matrix_result_streamer
//
// Captures a packed DIM_MAX x DIM_MAX result matrix from the matrix operation
// units and streams the active N x N sub-matrix (N = 2..DIM_MAX) out one
// element per beat, in row-major order, over a valid/ready handshake.
// Elements are passed through bit-exact.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   load_valid   load_matrix/load_size are valid
//   load_ready   streamer can accept a matrix (high in IDLE)
//   load_matrix  packed matrix, element (r,c) at [(r*DIM_MAX+c)*ELEM_W +: ELEM_W]
//   load_size    active dimension N
//   out_valid    out_data holds a valid element
//   out_ready    downstream accepts the element this cycle
//   out_data     current element
//   out_row      row index of out_data
//   out_col      column index of out_data
//   out_last     out_data is element (N-1,N-1)
//   busy         high while streaming
//   size_err     one-cycle pulse after a load with an illegal size
// ---------------------------------------------------------------------------
module matrix_result_streamer #(
   parameter int ELEM_W   = 8,
   parameter int DIM_MAX  = 5,
   parameter int MATRIX_W = ELEM_W * DIM_MAX * DIM_MAX
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load_valid,
   output logic                load_ready,
   input  logic [MATRIX_W-1:0] load_matrix,
   input  logic [2:0]          load_size,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ELEM_W-1:0]   out_data,
   output logic [2:0]          out_row,
   output logic [2:0]          out_col,
   output logic                out_last,
   output logic                busy,
   output logic                size_err
);

   localparam int NUM_ELEM   = DIM_MAX * DIM_MAX;
   localparam int IDX_W      = $clog2(NUM_ELEM);
   localparam int ELEM_SLOTS = 1 << IDX_W;

   typedef enum logic {
      ST_IDLE,
      ST_STREAM
   } state_t;

   state_t                state_q, state_d;
   logic [MATRIX_W-1:0]   matrix_q, matrix_d;
   logic [2:0]            size_q, size_d;
   logic [2:0]            row_q, row_d;
   logic [2:0]            col_q, col_d;
   logic                  size_err_q, size_err_d;

   // Unpack the captured matrix into an element table. The table is padded to
   // a power-of-two depth so every value of the element index selects a
   // defined entry.
   logic [ELEM_W-1:0]     elem [ELEM_SLOTS];
   logic [IDX_W-1:0]      elem_idx;
   logic [2:0]            size_m1;
   logic                  size_legal;
   logic                  last_beat;

   genvar gi;
   generate
      for (gi = 0; gi < ELEM_SLOTS; gi++) begin : g_elem
         if (gi < NUM_ELEM) begin : g_used
            assign elem[gi] = matrix_q[gi*ELEM_W +: ELEM_W];
         end else begin : g_pad
            assign elem[gi] = '0;
         end
      end
   endgenerate

   assign elem_idx   = IDX_W'(row_q) * IDX_W'(DIM_MAX) + IDX_W'(col_q);
   assign size_m1    = size_q - 3'd1;
   assign last_beat  = (row_q == size_m1) && (col_q == size_m1);
   assign size_legal = (load_size >= 3'd2) && (load_size <= 3'(DIM_MAX));

   always_comb begin
      state_d    = state_q;
      matrix_d   = matrix_q;
      size_d     = size_q;
      row_d      = row_q;
      col_d      = col_q;
      size_err_d = 1'b0;

      load_ready = 1'b0;
      out_valid  = 1'b0;
      out_data   = '0;
      out_last   = 1'b0;
      busy       = 1'b0;
      out_row    = row_q;
      out_col    = col_q;
      size_err   = size_err_q;

      unique case (state_q)
         ST_IDLE: begin
            load_ready = 1'b1;
            if (load_valid) begin
               if (size_legal) begin
                  matrix_d = load_matrix;
                  size_d   = load_size;
                  row_d    = 3'd0;
                  col_d    = 3'd0;
                  state_d  = ST_STREAM;
               end else begin
                  size_err_d = 1'b1;
               end
            end
         end

         ST_STREAM: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_data  = elem[elem_idx];
            out_last  = last_beat;
            if (out_ready) begin
               if (last_beat) begin
                  // Park the indices at (0,0) so IDLE presents a clean position.
                  row_d   = 3'd0;
                  col_d   = 3'd0;
                  state_d = ST_IDLE;
               end else if (col_q == size_m1) begin
                  col_d = 3'd0;
                  row_d = row_q + 3'd1;
               end else begin
                  col_d = col_q + 3'd1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         matrix_q   <= '0;
         size_q     <= 3'd0;
         row_q      <= 3'd0;
         col_q      <= 3'd0;
         size_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         matrix_q   <= matrix_d;
         size_q     <= size_d;
         row_q      <= row_d;
         col_q      <= col_d;
         size_err_q <= size_err_d;
      end
   end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// ---------------------------------------------------------------------------
// tb_matrix_result_streamer
//
// Directed bench for matrix_result_streamer. Each scenario task drives its
// own stimulus and compares the DUT outputs against hand-computed values.
// Outputs are sampled 1 ns after the rising edge; inputs change at the same
// point, well before the next edge.
// ---------------------------------------------------------------------------
module tb_matrix_result_streamer;

   logic         clk;
   logic         rst;
   logic         load_valid;
   logic         load_ready;
   logic [199:0] load_matrix;
   logic [2:0]   load_size;
   logic         out_valid;
   logic         out_ready;
   logic [7:0]   out_data;
   logic [2:0]   out_row;
   logic [2:0]   out_col;
   logic         out_last;
   logic         busy;
   logic         size_err;

   int total;
   int bad;

   matrix_result_streamer dut (
      .clk         (clk),
      .rst         (rst),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .load_matrix (load_matrix),
      .load_size   (load_size),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_row     (out_row),
      .out_col     (out_col),
      .out_last    (out_last),
      .busy        (busy),
      .size_err    (size_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Element k (row-major over the 5x5 array) holds k+1.
   function automatic logic [199:0] seq_matrix();
      logic [199:0] m;
      m = '0;
      for (int k = 0; k < 25; k++) m[k*8 +: 8] = 8'(k + 1);
      return m;
   endfunction

   // Element k holds 0xA0+k, with three boundary values planted in the 3x3 corner.
   function automatic logic [199:0] edge_matrix();
      logic [199:0] m;
      m = '0;
      for (int k = 0; k < 25; k++) m[k*8 +: 8] = 8'(8'hA0 + k);
      m[0*8 +: 8] = 8'h80;
      m[1*8 +: 8] = 8'hFF;
      m[5*8 +: 8] = 8'h7F;
      return m;
   endfunction

   task automatic test_reset();
      rst = 1'b1; load_valid = 1'b0; out_ready = 1'b0;
      load_matrix = '0; load_size = 3'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL reset_load_ready: got %b want 1", load_ready); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (size_err !== 1'b0) begin bad++; $display("FAIL reset_size_err: got %b want 0", size_err); end
      total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last: got %b want 0", out_last); end
      total++; if ({out_data, out_row, out_col} !== 14'h0) begin bad++; $display("FAIL reset_out_fields: got data=%0h row=%0d col=%0d want 0/0/0", out_data, out_row, out_col); end
      $display("test_reset done");
   endtask

   task automatic test_full5();
      load_matrix = seq_matrix(); load_size = 3'd5; load_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1 load_valid = 1'b0;
      for (int b = 0; b < 25; b++) begin
         total++; if (out_valid !== 1'b1 || load_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL full5_flags beat %0d: got v=%b lr=%b busy=%b want 1/0/1", b, out_valid, load_ready, busy); end
         total++; if (out_data !== 8'(b + 1)) begin bad++; $display("FAIL full5_data beat %0d: got %0d want %0d", b, out_data, b + 1); end
         total++; if (out_row !== 3'(b / 5) || out_col !== 3'(b % 5)) begin bad++; $display("FAIL full5_pos beat %0d: got (%0d,%0d) want (%0d,%0d)", b, out_row, out_col, b / 5, b % 5); end
         total++; if (out_last !== (b == 24)) begin bad++; $display("FAIL full5_last beat %0d: got %b want %b", b, out_last, (b == 24)); end
         $display("full5 beat %0d data=%0d row=%0d col=%0d last=%b", b, out_data, out_row, out_col, out_last);
         @(posedge clk); #1;
      end
      total++; if (out_valid !== 1'b0 || load_ready !== 1'b1) begin bad++; $display("FAIL full5_end: got v=%b lr=%b want 0/1", out_valid, load_ready); end
   endtask

   task automatic test_size2();
      int exp_d [4] = '{1, 2, 6, 7};
      load_matrix = seq_matrix(); load_size = 3'd2; load_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1 load_valid = 1'b0;
      for (int b = 0; b < 4; b++) begin
         total++; if (out_valid !== 1'b1 || out_data !== 8'(exp_d[b])) begin bad++; $display("FAIL size2_data beat %0d: got v=%b d=%0d want 1/%0d", b, out_valid, out_data, exp_d[b]); end
         total++; if (out_row !== 3'(b / 2) || out_col !== 3'(b % 2)) begin bad++; $display("FAIL size2_pos beat %0d: got (%0d,%0d) want (%0d,%0d)", b, out_row, out_col, b / 2, b % 2); end
         total++; if (out_last !== (b == 3)) begin bad++; $display("FAIL size2_last beat %0d: got %b want %b", b, out_last, (b == 3)); end
         $display("size2 beat %0d data=%0d row=%0d col=%0d last=%b", b, out_data, out_row, out_col, out_last);
         @(posedge clk); #1;
      end
      total++; if (out_valid !== 1'b0 || load_ready !== 1'b1) begin bad++; $display("FAIL size2_end: got v=%b lr=%b want 0/1", out_valid, load_ready); end
   endtask

   task automatic test_backpressure();
      int exp_d [9] = '{1, 2, 3, 6, 7, 8, 11, 12, 13};
      logic pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      int beat = 0;
      int cyc = 0;
      load_matrix = seq_matrix(); load_size = 3'd3; load_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1 load_valid = 1'b0;
      while (beat < 9 && cyc < 100) begin
         out_ready = pat[cyc % 5];
         total++; if (out_valid !== 1'b1 || out_data !== 8'(exp_d[beat])) begin bad++; $display("FAIL bp_data cyc %0d beat %0d: got v=%b d=%0d want 1/%0d", cyc, beat, out_valid, out_data, exp_d[beat]); end
         total++; if (out_row !== 3'(beat / 3) || out_col !== 3'(beat % 3) || out_last !== (beat == 8)) begin bad++; $display("FAIL bp_pos cyc %0d: got (%0d,%0d) last=%b want (%0d,%0d) last=%b", cyc, out_row, out_col, out_last, beat / 3, beat % 3, (beat == 8)); end
         $display("bp cyc %0d ready=%b data=%0d row=%0d col=%0d", cyc, out_ready, out_data, out_row, out_col);
         @(posedge clk); #1;
         if (out_ready) beat++;
         cyc++;
      end
      total++; if (beat !== 9) begin bad++; $display("FAIL bp_timeout: got %0d beats want 9", beat); end
      out_ready = 1'b1;
      total++; if (out_valid !== 1'b0 || load_ready !== 1'b1) begin bad++; $display("FAIL bp_end: got v=%b lr=%b want 0/1", out_valid, load_ready); end
   endtask

   task automatic test_size_err();
      logic [2:0] sizes [4] = '{3'd0, 3'd6, 3'd1, 3'd7};
      load_matrix = seq_matrix();
      for (int i = 0; i < 4; i++) begin
         load_size = sizes[i]; load_valid = 1'b1;
         @(posedge clk); #1 load_valid = 1'b0;
         total++; if (size_err !== 1'b1) begin bad++; $display("FAIL size_err_pulse size %0d: got %b want 1", sizes[i], size_err); end
         total++; if (out_valid !== 1'b0 || load_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL size_err_state size %0d: got v=%b lr=%b busy=%b want 0/1/0", sizes[i], out_valid, load_ready, busy); end
         @(posedge clk); #1;
         total++; if (size_err !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL size_err_clear size %0d: got err=%b v=%b want 0/0", sizes[i], size_err, out_valid); end
         $display("size_err size %0d checked", sizes[i]);
      end
   endtask

   task automatic test_reset_mid();
      load_matrix = seq_matrix(); load_size = 3'd5; load_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1 load_valid = 1'b0;
      for (int b = 0; b < 10; b++) begin
         total++; if (out_data !== 8'(b + 1)) begin bad++; $display("FAIL midrst_pre beat %0d: got %0d want %0d", b, out_data, b + 1); end
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      total++; if (out_valid !== 1'b0 || load_ready !== 1'b1 || out_last !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_abort: got v=%b lr=%b last=%b busy=%b want 0/1/0/0", out_valid, load_ready, out_last, busy); end
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_quiet: got v=%b want 0", out_valid); end
      load_valid = 1'b1;
      @(posedge clk); #1 load_valid = 1'b0;
      for (int b = 0; b < 25; b++) begin
         total++; if (out_valid !== 1'b1 || out_data !== 8'(b + 1) || out_row !== 3'(b / 5) || out_col !== 3'(b % 5)) begin bad++; $display("FAIL midrst_restream beat %0d: got v=%b d=%0d (%0d,%0d) want 1/%0d (%0d,%0d)", b, out_valid, out_data, out_row, out_col, b + 1, b / 5, b % 5); end
         @(posedge clk); #1;
      end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_end: got v=%b want 0", out_valid); end
      $display("reset_mid done");
   endtask

   task automatic test_back_to_back();
      int exp_a [4] = '{1, 2, 6, 7};
      logic [7:0] exp_b [9] = '{8'h80, 8'hFF, 8'hA2, 8'h7F, 8'hA6, 8'hA7, 8'hAA, 8'hAB, 8'hAC};
      load_matrix = seq_matrix(); load_size = 3'd2; load_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      // Second matrix presented while the first one is still streaming.
      load_matrix = edge_matrix(); load_size = 3'd3;
      for (int b = 0; b < 4; b++) begin
         total++; if (load_ready !== 1'b0 || out_data !== 8'(exp_a[b])) begin bad++; $display("FAIL b2b_first beat %0d: got lr=%b d=%0d want 0/%0d", b, load_ready, out_data, exp_a[b]); end
         @(posedge clk); #1;
      end
      total++; if (out_valid !== 1'b0 || load_ready !== 1'b1) begin bad++; $display("FAIL b2b_gap: got v=%b lr=%b want 0/1", out_valid, load_ready); end
      @(posedge clk); #1;
      load_valid = 1'b0;
      load_matrix = ~edge_matrix();
      for (int b = 0; b < 9; b++) begin
         total++; if (out_valid !== 1'b1 || out_data !== exp_b[b]) begin bad++; $display("FAIL b2b_second beat %0d: got v=%b d=%0h want 1/%0h", b, out_valid, out_data, exp_b[b]); end
         total++; if (out_row !== 3'(b / 3) || out_col !== 3'(b % 3) || out_last !== (b == 8)) begin bad++; $display("FAIL b2b_pos beat %0d: got (%0d,%0d) last=%b want (%0d,%0d) last=%b", b, out_row, out_col, out_last, b / 3, b % 3, (b == 8)); end
         $display("b2b beat %0d data=%0h row=%0d col=%0d", b, out_data, out_row, out_col);
         @(posedge clk); #1;
      end
      total++; if (out_valid !== 1'b0 || load_ready !== 1'b1) begin bad++; $display("FAIL b2b_end: got v=%b lr=%b want 0/1", out_valid, load_ready); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_full5();
      test_size2();
      test_backpressure();
      test_size_err();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
